// File: rtl/ext_link_pkg.sv
// Shared types and helpers for the external UART link transmitter and its ACK receiver.
// Defining EXT_LINK_PARITY_EN adds the parity-bit state to both state machines.
package ext_link_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START_BIT,
        DATA_BITS,
`ifdef EXT_LINK_PARITY_EN
        PARITY_BIT,
`endif
        STOP_BIT,
        WAIT_ACK,
        DONE,
        FAIL
    } state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
`ifdef EXT_LINK_PARITY_EN
        RX_PARITY,
`endif
        RX_STOP
    } rx_state_t;

    localparam logic [7:0] DEFAULT_ACK_BYTE = 8'b11001100;

    function automatic int clks_per_bit(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

endpackage

// File: rtl/ext_link_uart_rx.sv
// UART byte receiver: 2-flop synchroniser, mid-bit sampling, stop-bit framing check.
// With EXT_LINK_PARITY_EN defined an even-parity bit is expected before the stop bit.
module ext_link_uart_rx
    import ext_link_pkg::*;
#(
    parameter int UART_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 217
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx,
    output logic [UART_WIDTH-1:0] rx_byte,
    output logic                  rx_valid,
    output logic                  parity_err
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
    localparam int BIT_W = (UART_WIDTH > 1) ? $clog2(UART_WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(UART_WIDTH - 1);

    rx_state_t             state_reg, state_next;
    logic                  rx_meta_reg, rx_sync_reg, rx_prev_reg;
    logic [CNT_W-1:0]      cnt_reg, cnt_next;
    logic [BIT_W-1:0]      bit_idx_reg, bit_idx_next;
    logic [UART_WIDTH-1:0] shift_reg, shift_next;
    logic                  valid_reg, valid_next;
    logic                  perr_reg, perr_next;
`ifdef EXT_LINK_PARITY_EN
    logic                  par_reg, par_next;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_reg <= 1'b1;
            rx_sync_reg <= 1'b1;
            rx_prev_reg <= 1'b1;
            state_reg   <= RX_IDLE;
            cnt_reg     <= '0;
            bit_idx_reg <= '0;
            shift_reg   <= '0;
            valid_reg   <= 1'b0;
            perr_reg    <= 1'b0;
`ifdef EXT_LINK_PARITY_EN
            par_reg     <= 1'b0;
`endif
        end else begin
            rx_meta_reg <= rx;
            rx_sync_reg <= rx_meta_reg;
            rx_prev_reg <= rx_sync_reg;
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            bit_idx_reg <= bit_idx_next;
            shift_reg   <= shift_next;
            valid_reg   <= valid_next;
            perr_reg    <= perr_next;
`ifdef EXT_LINK_PARITY_EN
            par_reg     <= par_next;
`endif
        end
    end

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg + 1'b1;
        bit_idx_next = bit_idx_reg;
        shift_next   = shift_reg;
        valid_next   = 1'b0;
        perr_next    = perr_reg;
`ifdef EXT_LINK_PARITY_EN
        par_next     = par_reg;
`endif
        case (state_reg)
            RX_IDLE: begin
                // The edge cycle is the first start-bit cycle, so the count resumes at 1.
                cnt_next = CNT_W'(1);
                if (rx_prev_reg && !rx_sync_reg) state_next = RX_START;
            end
            RX_START: begin
                if (cnt_reg == CNT_HALF) begin
                    cnt_next     = '0;
                    bit_idx_next = '0;
                    state_next   = rx_sync_reg ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt_reg == CNT_LAST) begin
                    cnt_next   = '0;
                    shift_next = {rx_sync_reg, shift_reg[UART_WIDTH-1:1]};
                    if (bit_idx_reg == BIT_LAST) begin
`ifdef EXT_LINK_PARITY_EN
                        state_next = RX_PARITY;
`else
                        state_next = RX_STOP;
`endif
                    end else begin
                        bit_idx_next = bit_idx_reg + 1'b1;
                    end
                end
            end
`ifdef EXT_LINK_PARITY_EN
            RX_PARITY: begin
                if (cnt_reg == CNT_LAST) begin
                    cnt_next   = '0;
                    par_next   = rx_sync_reg;
                    state_next = RX_STOP;
                end
            end
`endif
            RX_STOP: begin
                if (cnt_reg == CNT_LAST) begin
                    state_next = RX_IDLE;
                    valid_next = rx_sync_reg;
`ifdef EXT_LINK_PARITY_EN
                    perr_next  = ^{shift_reg, par_reg};
`else
                    perr_next  = 1'b0;
`endif
                end
            end
            default: state_next = RX_IDLE;
        endcase
    end

    assign rx_byte    = shift_reg;
    assign rx_valid   = valid_reg;
    assign parity_err = perr_reg;

endmodule

// File: rtl/ext_link_tx.sv
// Reliable link transmitter: sends a word as UART bytes (low byte first), waits for an ACK
// byte and retransmits on timeout or wrong reply. EXT_LINK_PARITY_EN enables even parity.
module ext_link_tx
    import ext_link_pkg::*;
#(
    parameter int DATA_WIDTH         = 16,
    parameter int UART_WIDTH         = 8,
    parameter int CLK_FREQ           = 50_000_000,
    parameter int BAUD_RATE          = 230400,
    parameter int RETRANSMIT_COUNT   = 5,
    parameter int ACK_TIMEOUT_CYCLES = 50_000,
    parameter logic [UART_WIDTH-1:0] ACK_BYTE = UART_WIDTH'(DEFAULT_ACK_BYTE),
    localparam int RC_W = (RETRANSMIT_COUNT > 0) ? $clog2(RETRANSMIT_COUNT + 1) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] data,
    output logic                  ready,
    output logic                  busy,
    output logic                  done,
    output logic                  fail,
    output logic [RC_W-1:0]       retry_count,
    input  logic                  rx,
    output logic                  tx
);
    localparam int CPB    = clks_per_bit(CLK_FREQ, BAUD_RATE);
    localparam int BYTES  = (DATA_WIDTH + UART_WIDTH - 1) / UART_WIDTH;
    localparam int PAD_W  = BYTES * UART_WIDTH;
    localparam int CNT_W  = $clog2(CPB + 1);
    localparam int BIT_W  = (UART_WIDTH > 1) ? $clog2(UART_WIDTH) : 1;
    localparam int BYTE_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int TO_W   = $clog2(ACK_TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CPB - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(UART_WIDTH - 1);
    localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(BYTES - 1);
    localparam logic [TO_W-1:0]   TO_LOAD   = TO_W'(ACK_TIMEOUT_CYCLES - 1);
    localparam logic [RC_W-1:0]   RC_MAX    = RC_W'(RETRANSMIT_COUNT);

    state_t                state_reg, state_next;
    logic [CNT_W-1:0]      clk_cnt_reg, clk_cnt_next;
    logic [BIT_W-1:0]      bit_idx_reg, bit_idx_next;
    logic [BYTE_W-1:0]     byte_idx_reg, byte_idx_next;
    logic [RC_W-1:0]       retry_reg, retry_next;
    logic [TO_W-1:0]       timeout_reg, timeout_next;
    logic [PAD_W-1:0]      data_reg, data_next;

    logic [UART_WIDTH-1:0] byte_arr [BYTES];
    logic [UART_WIDTH-1:0] cur_byte;
    logic [UART_WIDTH-1:0] rx_byte;
    logic                  rx_valid, rx_parity_err, ack_ok;
    logic                  bit_end;
    logic [CNT_W-1:0]      cnt_step;

    for (genvar gi = 0; gi < BYTES; gi++) begin : g_bytes
        assign byte_arr[gi] = data_reg[gi*UART_WIDTH +: UART_WIDTH];
    end
    assign cur_byte = byte_arr[byte_idx_reg];

    ext_link_uart_rx #(
        .UART_WIDTH   (UART_WIDTH),
        .CLKS_PER_BIT (CPB)
    ) u_rx (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .rx_byte    (rx_byte),
        .rx_valid   (rx_valid),
        .parity_err (rx_parity_err)
    );

    assign ack_ok   = rx_valid && !rx_parity_err && (rx_byte == ACK_BYTE);
    assign bit_end  = (clk_cnt_reg == CNT_LAST);
    assign cnt_step = bit_end ? '0 : clk_cnt_reg + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            clk_cnt_reg  <= '0;
            bit_idx_reg  <= '0;
            byte_idx_reg <= '0;
            retry_reg    <= '0;
            timeout_reg  <= '0;
            data_reg     <= '0;
        end else begin
            state_reg    <= state_next;
            clk_cnt_reg  <= clk_cnt_next;
            bit_idx_reg  <= bit_idx_next;
            byte_idx_reg <= byte_idx_next;
            retry_reg    <= retry_next;
            timeout_reg  <= timeout_next;
            data_reg     <= data_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        clk_cnt_next  = '0;
        bit_idx_next  = bit_idx_reg;
        byte_idx_next = byte_idx_reg;
        retry_next    = retry_reg;
        timeout_next  = timeout_reg;
        data_next     = data_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    data_next                   = '0;
                    data_next[DATA_WIDTH-1:0]   = data;
                    retry_next                  = '0;
                    byte_idx_next               = '0;
                    state_next                  = START_BIT;
                end
            end
            START_BIT: begin
                clk_cnt_next = cnt_step;
                if (bit_end) begin
                    bit_idx_next = '0;
                    state_next   = DATA_BITS;
                end
            end
            DATA_BITS: begin
                clk_cnt_next = cnt_step;
                if (bit_end) begin
                    if (bit_idx_reg == BIT_LAST) begin
`ifdef EXT_LINK_PARITY_EN
                        state_next = PARITY_BIT;
`else
                        state_next = STOP_BIT;
`endif
                    end else begin
                        bit_idx_next = bit_idx_reg + 1'b1;
                    end
                end
            end
`ifdef EXT_LINK_PARITY_EN
            PARITY_BIT: begin
                clk_cnt_next = cnt_step;
                if (bit_end) state_next = STOP_BIT;
            end
`endif
            STOP_BIT: begin
                clk_cnt_next = cnt_step;
                if (bit_end) begin
                    if (byte_idx_reg != BYTE_LAST) begin
                        byte_idx_next = byte_idx_reg + 1'b1;
                        state_next    = START_BIT;
                    end else begin
                        timeout_next = TO_LOAD;
                        state_next   = WAIT_ACK;
                    end
                end
            end
            WAIT_ACK: begin
                timeout_next = timeout_reg - 1'b1;
                // A valid ACK takes priority over a coincident timeout expiry.
                if (ack_ok) begin
                    state_next = DONE;
                end else if (rx_valid || (timeout_reg == '0)) begin
                    if (retry_reg != RC_MAX) begin
                        retry_next    = retry_reg + 1'b1;
                        byte_idx_next = '0;
                        state_next    = START_BIT;
                    end else begin
                        state_next = FAIL;
                    end
                end
            end
            DONE:    state_next = IDLE;
            FAIL:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        tx = 1'b1;
        case (state_reg)
            START_BIT: tx = 1'b0;
            DATA_BITS: tx = cur_byte[bit_idx_reg];
`ifdef EXT_LINK_PARITY_EN
            PARITY_BIT: tx = ^cur_byte;
`endif
            default:   tx = 1'b1;
        endcase
    end

    assign ready       = (state_reg == IDLE);
    assign busy        = ~ready;
    assign done        = (state_reg == DONE);
    assign fail        = (state_reg == FAIL);
    assign retry_count = retry_reg;

endmodule

// File: tb/tb_ext_link_tx.sv
// Directed bench for ext_link_tx: decodes tx bytes, drives ACK replies on rx, checks pulses.
`timescale 1ns/1ps
module tb_ext_link_tx;
    localparam int CPB     = 50;
    localparam int TIMEOUT = 1000;
`ifdef EXT_LINK_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = NBITS * CPB;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        rx = 1'b1;
    logic [15:0] data = '0;
    logic        ready, busy, done, fail, tx;
    logic [2:0]  retry_count;

    ext_link_tx #(
        .DATA_WIDTH         (16),
        .UART_WIDTH         (8),
        .CLK_FREQ           (50_000_000),
        .BAUD_RATE          (1_000_000),
        .RETRANSMIT_COUNT   (5),
        .ACK_TIMEOUT_CYCLES (TIMEOUT),
        .ACK_BYTE           (8'hCC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .data        (data),
        .ready       (ready),
        .busy        (busy),
        .done        (done),
        .fail        (fail),
        .retry_count (retry_count),
        .rx          (rx),
        .tx          (tx)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   done_cnt = 0;
    int   fail_cnt = 0;
    logic pulse_prev = 1'b0;
    logic ready_after = 1'b0;
    always @(negedge clk) begin
        if (done) done_cnt <= done_cnt + 1;
        if (fail) fail_cnt <= fail_cnt + 1;
        if (pulse_prev) ready_after <= ready;
        pulse_prev <= done | fail;
    end

    typedef struct { logic [7:0] b; logic p; int t0; } rec_t;
    rec_t mon_q[$];

    // Decodes every character on tx; t0 is the first start-bit cycle.
    initial begin : monitor
        rec_t r;
        forever begin
            @(negedge clk);
            if (tx === 1'b0) begin
                r.t0 = cyc;
                r.b  = '0;
                r.p  = 1'b0;
                repeat (CPB/2 + CPB) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    r.b[i] = tx;
                    repeat (CPB) @(negedge clk);
                end
`ifdef EXT_LINK_PARITY_EN
                r.p = tx;
                repeat (CPB) @(negedge clk);
`endif
                mon_q.push_back(r);
            end
        end
    end

`ifdef EXT_LINK_PARITY_EN
    logic rx_bad_par = 1'b0;
`endif
    int rx_stop_cyc = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_bytes(input int n, input int budget);
        int t = 0;
        while (mon_q.size() < n && t < budget) begin
            @(negedge clk);
            t++;
        end
        check($sformatf("byte_count_%0d", n), mon_q.size(), n);
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic do_start(input logic [15:0] d);
        @(negedge clk);
        data  = d;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_rx(input logic [7:0] b);
        @(negedge clk);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
`ifdef EXT_LINK_PARITY_EN
        rx = (^b) ^ rx_bad_par;
        repeat (CPB) @(negedge clk);
`endif
        rx = 1'b1;
        rx_stop_cyc = cyc;
        repeat (CPB) @(negedge clk);
    endtask

    initial begin
        int base_d, base_f, gap, t;

        repeat (3) @(negedge clk);
        check("rst_tx", tx, 1);
        check("rst_ready", ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_fail", fail, 0);
        check("rst_retry", retry_count, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Single transfer, ACK 100 clk after the final stop bit.
        base_d = done_cnt; base_f = fail_cnt; mon_q.delete();
        do_start(16'hA53C);
        check("t1_tx_low_next_cycle", tx, 0);
        check("t1_busy", busy, 1);
        wait_bytes(2, 3*FRAME);
        check("t1_byte0", mon_q[0].b, 8'h3C);
        check("t1_byte1", mon_q[1].b, 8'hA5);
        check("t1_back_to_back", mon_q[1].t0 - mon_q[0].t0, FRAME);
        wait_cyc(mon_q[1].t0 + FRAME + 99);
        send_rx(8'hCC);
        repeat (5) @(negedge clk);
        check("t1_done_pulses", done_cnt - base_d, 1);
        check("t1_no_fail", fail_cnt - base_f, 0);
        check("t1_retry", retry_count, 0);
        check("t1_ready_after_done", ready_after, 1);
        check("t1_no_retx", mon_q.size(), 2);

        // No reply: six attempts spaced by the timeout, then fail.
        base_d = done_cnt; base_f = fail_cnt; mon_q.delete();
        do_start(16'hA53C);
        wait_bytes(12, 6*(2*FRAME + TIMEOUT) + FRAME);
        for (int i = 0; i < 12; i++) begin
            check($sformatf("t2_byte%0d", i), mon_q[i].b, (i % 2 == 1) ? 8'hA5 : 8'h3C);
            if (i > 0) begin
                gap = mon_q[i].t0 - mon_q[i-1].t0;
                check($sformatf("t2_gap%0d", i), gap, (i % 2 == 1) ? FRAME : FRAME + TIMEOUT);
            end
        end
        t = 0;
        while (fail_cnt == base_f && t < FRAME + TIMEOUT + 20) begin
            @(negedge clk);
            t++;
        end
        repeat (3) @(negedge clk);
        check("t2_fail_pulses", fail_cnt - base_f, 1);
        check("t2_no_done", done_cnt - base_d, 0);
        check("t2_retry", retry_count, 5);
        check("t2_ready_after_fail", ready_after, 1);
        check("t2_attempts", mon_q.size(), 12);

        // Wrong reply triggers an immediate retransmit, then ACK.
        base_d = done_cnt; base_f = fail_cnt; mon_q.delete();
        do_start(16'hA53C);
        wait_bytes(2, 3*FRAME);
        wait_cyc(mon_q[1].t0 + FRAME + 99);
        send_rx(8'h33);
        wait_bytes(4, 3*FRAME);
        gap = mon_q[2].t0 - rx_stop_cyc;
        check("t3_retx_prompt", (gap > 0 && gap <= CPB) ? 1 : 0, 1);
        check("t3_byte2", mon_q[2].b, 8'h3C);
        check("t3_byte3", mon_q[3].b, 8'hA5);
        wait_cyc(mon_q[3].t0 + FRAME + 99);
        send_rx(8'hCC);
        repeat (5) @(negedge clk);
        check("t3_done_pulses", done_cnt - base_d, 1);
        check("t3_retry", retry_count, 1);
        check("t3_no_fail", fail_cnt - base_f, 0);

        // start while busy is ignored.
        base_d = done_cnt; mon_q.delete();
        do_start(16'hA53C);
        wait_bytes(1, 2*FRAME);
        repeat (CPB) @(negedge clk);
        check("t4_busy_ready", ready, 0);
        data  = 16'h1234;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        data  = 16'h0000;
        wait_bytes(2, 2*FRAME);
        check("t4_byte0", mon_q[0].b, 8'h3C);
        check("t4_byte1", mon_q[1].b, 8'hA5);
        wait_cyc(mon_q[1].t0 + FRAME + 99);
        send_rx(8'hCC);
        repeat (5) @(negedge clk);
        check("t4_done_pulses", done_cnt - base_d, 1);
        check("t4_only_two_bytes", mon_q.size(), 2);

        // Asynchronous reset in the middle of data bit 0 (a 0 bit of 8'h3C).
        base_d = done_cnt; base_f = fail_cnt; mon_q.delete();
        do_start(16'hA53C);
        repeat (CPB + CPB/2) @(negedge clk);
        check("t5_tx_data_bit0", tx, 0);
        #1 rst = 1'b1;
        #1;
        check("t5_rst_tx_async", tx, 1);
        check("t5_rst_ready_async", ready, 1);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2*FRAME) @(negedge clk);
        check("t5_no_done", done_cnt - base_d, 0);
        check("t5_no_fail", fail_cnt - base_f, 0);
        check("t5_retry_clear", retry_count, 0);
        check("t5_tx_idle", tx, 1);
        mon_q.delete();
        do_start(16'h5AC3);
        wait_bytes(2, 3*FRAME);
        check("t5_byte0", mon_q[0].b, 8'hC3);
        check("t5_byte1", mon_q[1].b, 8'h5A);
        wait_cyc(mon_q[1].t0 + FRAME + 99);
        send_rx(8'hCC);
        repeat (5) @(negedge clk);
        check("t5_done_pulses", done_cnt - base_d, 1);

`ifdef EXT_LINK_PARITY_EN
        // Parity bits on tx; a bad-parity ACK is a retry event.
        base_d = done_cnt; mon_q.delete();
        do_start(16'h003C);
        wait_bytes(2, 3*FRAME);
        check("t6_byte0", mon_q[0].b, 8'h3C);
        check("t6_par0", mon_q[0].p, 0);
        check("t6_byte1", mon_q[1].b, 8'h00);
        check("t6_par1", mon_q[1].p, 0);
        wait_cyc(mon_q[1].t0 + FRAME + 99);
        rx_bad_par = 1'b1;
        send_rx(8'hCC);
        rx_bad_par = 1'b0;
        wait_bytes(4, 3*FRAME);
        check("t6_bad_par_retry", retry_count, 1);
        check("t6_bad_par_no_done", done_cnt - base_d, 0);
        wait_cyc(mon_q[3].t0 + FRAME + 99);
        send_rx(8'hCC);
        repeat (5) @(negedge clk);
        check("t6_done_pulses", done_cnt - base_d, 1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ext_link_tx.md
# ext_link_tx

Reliable external-link transmitter for the FPGA-to-FPGA UART channel. It serialises a DATA_WIDTH word as one or more UART bytes (low byte first) on `tx`. It then waits on `rx` for an acknowledgement byte and retransmits the whole word on timeout or a wrong reply, up to RETRANSMIT_COUNT times. It sits between the external-communication controller and the GPIO UART pins, and generalises the single-byte send/ACK path to arbitrary word width, clock rate and retry policy.

## Interface
- DATA_WIDTH, 16, payload word width; BYTES = ceil(DATA_WIDTH/UART_WIDTH); unused MSBs of the last byte are sent as 0.
- UART_WIDTH, 8, data bits per UART character.
- CLK_FREQ, 50_000_000, clock frequency in Hz.
- BAUD_RATE, 230400, link baud rate; CLKS_PER_BIT = CLK_FREQ/BAUD_RATE, integer truncation (217 at defaults).
- RETRANSMIT_COUNT, 5, retries after the first attempt, so 1+RETRANSMIT_COUNT attempts in total.
- ACK_TIMEOUT_CYCLES, 50_000, clocks to wait for the ACK after the last stop bit of an attempt (1 ms at defaults).
- ACK_BYTE, 8'b11001100, the expected acknowledgement character.
- clk  in  1  single system clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; accepted only in a cycle where ready=1.
- data  in  DATA_WIDTH  word to send; latched on accept.
- ready  out  1  high in IDLE.
- busy  out  1  equal to ~ready.
- done  out  1  one-cycle pulse when a valid ACK is received.
- fail  out  1  one-cycle pulse when all attempts are exhausted.
- retry_count  out  $clog2(RETRANSMIT_COUNT+1)  retries used in the current or last transfer.
- rx  in  1  UART line from the remote side, asynchronous.
- tx  out  1  UART line to the remote side; idles high.

## Operation
- States: IDLE, START_BIT, DATA_BITS, (PARITY_BIT), STOP_BIT, WAIT_ACK, DONE, FAIL.
- IDLE: accept start. On accept, latch data, clear retry_count, clear byte_idx, go to START_BIT.
- Character framing: start bit 0, UART_WIDTH data bits LSB first, optional parity bit, one stop bit 1. Each bit lasts CLKS_PER_BIT cycles.
- STOP_BIT end:
  - if byte_idx < BYTES-1: increment byte_idx and go to START_BIT. There is no idle gap between bytes.
  - otherwise: load the timeout counter and go to WAIT_ACK.
- WAIT_ACK:
  - a received byte equal to ACK_BYTE goes to DONE.
  - any other received byte, or timeout expiry, is a retry event.
  - on a retry event with retry_count < RETRANSMIT_COUNT: increment retry_count, set byte_idx=0, go to START_BIT.
  - on a retry event otherwise: go to FAIL.
- DONE and FAIL each last one cycle, pulse their output, then return to IDLE.
- Receiver:
  - rx passes through a 2-flop synchroniser.
  - a falling edge is confirmed as a start bit by a low sample at CLKS_PER_BIT/2.
  - data bits are sampled at mid-bit.
  - a byte is valid at the mid-stop-bit sample, and only if that sample is 1; otherwise it is discarded as a framing error.
  - bytes completing outside WAIT_ACK are discarded.
- Boundary conditions:
  - start while busy is ignored, and the latched data is unchanged.
  - an ACK arriving in the same cycle as timeout expiry wins (DONE).
  - RETRANSMIT_COUNT=0 means a single attempt.
  - rst mid-operation: tx goes to 1 immediately, the state machine returns to IDLE, all counters clear, and no done/fail pulse is generated.

## Timing
- Reset values: tx=1, ready=1, busy=0, done=0, fail=0, retry_count=0.
- Accept cycle N: tx goes low in cycle N+1.
- Frame length: one character is (UART_WIDTH+2)×CLKS_PER_BIT cycles, plus CLKS_PER_BIT with parity. One attempt is BYTES × that.
- Timeout: the counter starts the cycle after the final stop bit ends. Expiry occurs ACK_TIMEOUT_CYCLES cycles later.
- ACK latency: done rises 1 cycle after the receiver validates the ACK byte. Sync latency is 2 cycles from the rx pin.
- Handshake: ready returns high the cycle after the done/fail pulse. start in that cycle is accepted.

## Configuration
- EXT_LINK_PARITY_EN defined:
  - an even-parity bit is inserted after the data bits of every transmitted character.
  - the receiver expects a parity bit on the ACK character.
  - a received byte with a parity error counts as a non-ACK, i.e. a retry event.
- EXT_LINK_PARITY_EN undefined:
  - no parity bit is sent or expected.
  - PARITY_BIT state and parity logic are absent.

## Structure
- Shared package `ext_link_pkg`: state enum type, default ACK_BYTE, `CLKS_PER_BIT` helper function.
- Sub-module `ext_link_uart_rx`: synchroniser plus byte receiver, outputs byte/valid/parity_err. It is instanced once and reusable by the receive-side link block.
- Transmit serialiser, retry and timeout logic stay in `ext_link_tx`.

## Test plan
- Defaults, data=16'hA53C, ACK 8'hCC returned 100 clk after the final stop bit -> tx carries 8'h3C then 8'hA5 back-to-back; done pulses once; retry_count=0; ready high the next cycle.
- ACK_TIMEOUT_CYCLES=1000, no reply -> 6 identical 2-byte attempts, each starting 1000 clk after the previous stop bit; fail pulses once; retry_count=5.
- First reply 8'h33, second reply 8'hCC -> retransmit starts immediately after the 8'h33 is validated; done; retry_count=1.
- start with data=16'h1234 during the second byte of a 16'hA53C transfer -> ignored; only 8'h3C/8'hA5 appear on tx.
- rst asserted mid data bit of the first byte -> tx=1 and ready=1 with no clock edge needed; no done/fail pulse; a fresh start after release transmits correctly.
- EXT_LINK_PARITY_EN defined, data=16'h003C -> parity bits 0 (8'h3C) and 0 (8'h00); an ACK 8'hCC sent with parity 1 triggers a retry; an ACK with parity 0 gives done.
